// File: rtl/kuart_pkg.sv
// Shared definitions for the kernel UART receive path and the simulation finisher.
// Holds the receiver state encoding, the default bit period and common character codes.
package kuart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } kuart_state_e;

  localparam int unsigned KUART_DEFAULT_CLKS_PER_BIT = 16;

  localparam logic [7:0] KUART_CH_DOT = 8'h2E;
  localparam logic [7:0] KUART_CH_R   = 8'h72;

  // Saturating increment so a long run of errors never wraps back to a small count.
  function automatic logic [15:0] kuart_sat_inc16(input logic [15:0] val);
    if (val == 16'hFFFF) begin
      return val;
    end else begin
      return val + 16'd1;
    end
  endfunction

endpackage

// File: rtl/kuart_sync2.sv
// Two-flop synchronizer for an asynchronous, idle-high input pin.
// Both stages reset to 1 so a reset never fabricates a falling edge.
module kuart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Synchronizer stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/kuart_rx_deser.sv
// 8N1 LSB-first UART receiver turning the CPU TX line into one-cycle byte strobes,
// with a wrapping byte counter and a saturating framing-error counter.
module kuart_rx_deser
  import kuart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = KUART_DEFAULT_CLKS_PER_BIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rxd,
  output logic [7:0]  kuart_byte,
  output logic        kuart_byte_valid,
  output logic        frame_err,
  output logic [31:0] rx_count,
  output logic [15:0] err_count
);

  if ((CLKS_PER_BIT < 4) || ((CLKS_PER_BIT % 2) != 0)) begin : g_bad_clks_per_bit
    $error("kuart_rx_deser: CLKS_PER_BIT must be even and >= 4");
  end

  localparam int unsigned TICK_W = $clog2(CLKS_PER_BIT);
  localparam logic [TICK_W-1:0] TICK_ZERO = TICK_W'(0);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(CLKS_PER_BIT / 2 - 1);

  logic rxs;

  kuart_state_e      state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [7:0]        shift_q, shift_d;
  // Stop-bit verdicts; the output stage below turns them into strobes one edge later.
  logic              ok_q, ok_d;
  logic              bad_q, bad_d;
  logic [7:0]        byte_q, byte_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;
  logic [31:0]       rx_count_q, rx_count_d;
  logic [15:0]       err_count_q, err_count_d;

  kuart_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (rxs)
  );

  // Receiver FSM: start validation, bit sampling and stop-bit check.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    ok_d     = 1'b0;
    bad_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          tick_d  = TICK_ZERO;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (tick_q == HALF_LAST) begin
          if (rxs) begin
            state_d = IDLE;
          end else begin
            state_d  = DATA;
            tick_d   = TICK_ZERO;
            bitcnt_d = 3'd0;
          end
        end else begin
          tick_d = tick_q + TICK_ONE;
        end
      end
      DATA: begin
        if (tick_q == TICK_LAST) begin
          shift_d[bitcnt_q] = rxs;
          tick_d            = TICK_ZERO;
          if (bitcnt_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end else begin
          tick_d = tick_q + TICK_ONE;
        end
      end
      STOP: begin
        if (tick_q == TICK_LAST) begin
          tick_d = TICK_ZERO;
          if (rxs) begin
            ok_d    = 1'b1;
            state_d = IDLE;
          end else begin
            bad_d   = 1'b1;
            state_d = BREAK;
          end
        end else begin
          tick_d = tick_q + TICK_ONE;
        end
      end
      BREAK: begin
        if (rxs) begin
          state_d = IDLE;
        end else begin
          state_d = BREAK;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output stage: strobes, held byte and counters.
  always_comb begin
    valid_d     = ok_q;
    ferr_d      = bad_q;
    byte_d      = byte_q;
    rx_count_d  = rx_count_q;
    err_count_d = err_count_q;
    if (ok_q) begin
      byte_d     = shift_q;
      rx_count_d = rx_count_q + 32'd1;
    end else begin
      byte_d     = byte_q;
    end
    if (bad_q) begin
      err_count_d = kuart_sat_inc16(err_count_q);
    end else begin
      err_count_d = err_count_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tick_q      <= TICK_ZERO;
      bitcnt_q    <= 3'd0;
      shift_q     <= 8'h00;
      ok_q        <= 1'b0;
      bad_q       <= 1'b0;
      byte_q      <= 8'h00;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      rx_count_q  <= 32'd0;
      err_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      ok_q        <= ok_d;
      bad_q       <= bad_d;
      byte_q      <= byte_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
      rx_count_q  <= rx_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign kuart_byte       = byte_q;
  assign kuart_byte_valid = valid_q;
  assign frame_err        = ferr_q;
  assign rx_count         = rx_count_q;
  assign err_count        = err_count_q;

endmodule

// File: tb/tb_kuart_rx_deser.sv
// Directed bench for kuart_rx_deser at 16 clocks per bit: timing, back-to-back
// frames, false starts, framing errors with break, and reset mid-frame.
module tb_kuart_rx_deser;

  localparam int N = 16;

  logic        clk;
  logic        rst_n;
  logic        rxd;
  logic [7:0]  kuart_byte;
  logic        kuart_byte_valid;
  logic        frame_err;
  logic [31:0] rx_count;
  logic [15:0] err_count;

  int nvec = 0;
  int nmis = 0;
  int cyc = 0;
  int overlap = 0;
  int vtime[$];
  logic [7:0] vbyte[$];
  int ftime[$];
  int t0, t1, t2, t3;
  int nv_before;

  kuart_rx_deser #(.CLKS_PER_BIT(N)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rxd              (rxd),
    .kuart_byte       (kuart_byte),
    .kuart_byte_valid (kuart_byte_valid),
    .frame_err        (frame_err),
    .rx_count         (rx_count),
    .err_count        (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe cycle with the edge number that registered it.
  always @(negedge clk) begin
    if (kuart_byte_valid) begin
      vtime.push_back(cyc);
      vbyte.push_back(kuart_byte);
    end
    if (frame_err) ftime.push_back(cyc);
    if (kuart_byte_valid && frame_err) overlap <= overlap + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nmis++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after an edge; returns the edge that first samples the start bit.
  task automatic send_frame(input logic [7:0] data, input logic stop_v, input logic end_v,
                            output int t_first);
    rxd = 1'b0;
    t_first = cyc + 1;
    repeat (N) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      repeat (N) @(posedge clk);
      #1;
    end
    rxd = stop_v;
    repeat (N) @(posedge clk);
    #1;
    rxd = end_v;
  endtask

  initial begin
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_byte", {24'd0, kuart_byte}, 32'h0);
    chk("rst_valid", {31'd0, kuart_byte_valid}, 32'h0);
    chk("rst_ferr", {31'd0, frame_err}, 32'h0);
    chk("rst_rxcnt", rx_count, 32'h0);
    chk("rst_errcnt", {16'd0, err_count}, 32'h0);

    repeat (1000) @(posedge clk);
    #1;
    chk("idle_strobes", vtime.size(), 32'd0);
    chk("idle_ferr", ftime.size(), 32'd0);
    chk("idle_rxcnt", rx_count, 32'h0);
    chk("idle_byte", {24'd0, kuart_byte}, 32'h0);

    // 0x2E: strobe registered 155 edges after the first low sample.
    send_frame(8'h2E, 1'b1, 1'b1, t0);
    repeat (5) @(posedge clk);
    #1;
    chk("dot_count", vtime.size(), 32'd1);
    chk("dot_latency", vtime[0] - t0, 32'd155);
    chk("dot_strobe_byte", {24'd0, vbyte[0]}, 32'h2E);
    chk("dot_byte", {24'd0, kuart_byte}, 32'h2E);
    chk("dot_rxcnt", rx_count, 32'd1);

    // Back-to-back frames with no idle gap.
    send_frame(8'h55, 1'b1, 1'b1, t1);
    send_frame(8'h72, 1'b1, 1'b1, t2);
    send_frame(8'hFF, 1'b1, 1'b1, t3);
    repeat (5) @(posedge clk);
    #1;
    chk("b2b_count", vtime.size(), 32'd4);
    chk("b2b_lat0", vtime[1] - t1, 32'd155);
    chk("b2b_gap1", vtime[2] - vtime[1], 32'd160);
    chk("b2b_gap2", vtime[3] - vtime[2], 32'd160);
    chk("b2b_v0", {24'd0, vbyte[1]}, 32'h55);
    chk("b2b_v1", {24'd0, vbyte[2]}, 32'h72);
    chk("b2b_v2", {24'd0, vbyte[3]}, 32'hFF);
    chk("b2b_rxcnt", rx_count, 32'd4);

    // Six-cycle glitch is a false start, then a real frame.
    rxd = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rxd = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    chk("glitch_count", vtime.size(), 32'd4);
    chk("glitch_ferr", ftime.size(), 32'd0);
    send_frame(8'hA5, 1'b1, 1'b1, t0);
    repeat (5) @(posedge clk);
    #1;
    chk("a5_count", vtime.size(), 32'd5);
    chk("a5_byte", {24'd0, kuart_byte}, 32'hA5);
    chk("a5_rxcnt", rx_count, 32'd5);

    // Low stop bit followed by a long break.
    send_frame(8'h41, 1'b0, 1'b0, t0);
    repeat (500) @(posedge clk);
    #1;
    chk("brk_ferr_count", ftime.size(), 32'd1);
    chk("brk_ferr_latency", ftime[0] - t0, 32'd155);
    chk("brk_errcnt", {16'd0, err_count}, 32'd1);
    chk("brk_byte", {24'd0, kuart_byte}, 32'hA5);
    chk("brk_no_strobe", vtime.size(), 32'd5);
    rxd = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    send_frame(8'h42, 1'b1, 1'b1, t0);
    repeat (5) @(posedge clk);
    #1;
    chk("after_brk_byte", {24'd0, kuart_byte}, 32'h42);
    chk("after_brk_rxcnt", rx_count, 32'd6);
    chk("after_brk_errcnt", {16'd0, err_count}, 32'd1);

    // Reset in the middle of the data bits of 0x33.
    nv_before = vtime.size();
    rxd = 1'b0;
    repeat (N) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      rxd = (8'h33 >> i) & 8'h01;
      repeat (N) @(posedge clk);
      #1;
    end
    repeat (N / 2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_byte", {24'd0, kuart_byte}, 32'h0);
    chk("mid_rst_rxcnt", rx_count, 32'h0);
    chk("mid_rst_errcnt", {16'd0, err_count}, 32'h0);
    rxd = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (N * 12) @(posedge clk);
    #1;
    chk("mid_rst_no_strobe", vtime.size() - nv_before, 32'd0);
    send_frame(8'h34, 1'b1, 1'b1, t0);
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_count", vtime.size() - nv_before, 32'd1);
    chk("post_rst_byte", {24'd0, kuart_byte}, 32'h34);
    chk("post_rst_rxcnt", rx_count, 32'd1);
    chk("post_rst_latency", vtime[vtime.size() - 1] - t0, 32'd155);
    chk("no_overlap", overlap, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
